// File: rtl/sipo_rx_sched.sv
// Round-robin scheduler that time-shares one external SIPO deserializer among NUM_CH
// serial requesters and presents each captured word with its channel tag on a valid/ready port.
module sipo_rx_sched #(
  parameter int unsigned NUM_CH = 4,
  parameter int unsigned SIZE   = 8,
  parameter int unsigned CW     = $clog2(NUM_CH)
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [NUM_CH-1:0] req,
  input  logic [NUM_CH-1:0] ser_in,
  output logic [NUM_CH-1:0] gnt,
  output logic              sipo_en,
  output logic              sipo_in,
  output logic              sipo_clr,
  input  logic [SIZE-1:0]   sipo_out,
  input  logic              sipo_done,
  output logic [SIZE-1:0]   word_out,
  output logic [CW-1:0]     word_ch,
  output logic              word_valid,
  input  logic              word_ready,
  output logic              busy,
  output logic              abort
);

  localparam int unsigned BW = (SIZE > 1) ? $clog2(SIZE) : 1;

  typedef enum logic [1:0] {IDLE, SHIFT, CAPTURE, HOLD} state_t;

  state_t        state;
  logic [CW-1:0] last;
  logic [CW-1:0] cur;
  logic [CW-1:0] pick;
  logic [CW-1:0] cand;
  logic [BW-1:0] cnt;
  logic          found;

  // First requester after the last served channel, wrapping modulo NUM_CH.
  always_comb begin
    pick  = '0;
    cand  = '0;
    found = 1'b0;
    for (int unsigned i = 1; i <= NUM_CH; i++) begin
      cand = CW'((32'(last) + i) % NUM_CH);
      if (!found && req[cand]) begin
        found = 1'b1;
        pick  = cand;
      end
    end
  end

  assign sipo_in = sipo_en & ser_in[cur];

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state      <= IDLE;
      gnt        <= '0;
      sipo_en    <= 1'b0;
      sipo_clr   <= 1'b1;
      busy       <= 1'b0;
      abort      <= 1'b0;
      word_valid <= 1'b0;
      word_out   <= '0;
      word_ch    <= '0;
      cnt        <= '0;
      cur        <= '0;
      last       <= CW'(NUM_CH - 1);
    end else begin
      sipo_clr <= 1'b0;
      abort    <= 1'b0;
      case (state)
        IDLE: begin
          if (found) begin
            gnt     <= NUM_CH'(1) << pick;
            sipo_en <= 1'b1;
            cur     <= pick;
            cnt     <= '0;
            busy    <= 1'b1;
            state   <= SHIFT;
          end
        end
        SHIFT: begin
          // A requester dropping req mid-frame discards the partial word.
          if (!req[cur]) begin
            gnt      <= '0;
            sipo_en  <= 1'b0;
            abort    <= 1'b1;
            sipo_clr <= 1'b1;
            last     <= cur;
            busy     <= 1'b0;
            state    <= IDLE;
          end else if (cnt == BW'(SIZE - 1)) begin
            gnt     <= '0;
            sipo_en <= 1'b0;
            state   <= CAPTURE;
          end else begin
            cnt <= cnt + BW'(1);
          end
        end
        CAPTURE: begin
          if (sipo_done) begin
            word_out   <= sipo_out;
            word_ch    <= cur;
            word_valid <= 1'b1;
            state      <= HOLD;
          end else begin
            abort    <= 1'b1;
            sipo_clr <= 1'b1;
            last     <= cur;
            busy     <= 1'b0;
            state    <= IDLE;
          end
        end
        HOLD: begin
          if (word_ready) begin
            word_valid <= 1'b0;
            last       <= cur;
            busy       <= 1'b0;
            state      <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/sipo_rx_sched.md
Name: sipo_rx_sched

Overview:
- Round-robin scheduler that shares one external SIPO deserializer between NUM_CH serial requesters.
- Grants one requester at a time and drives the SIPO enable and serial input for exactly SIZE bits.
- Captures the parallel word when the SIPO reports done, then presents it with its channel tag on a valid/ready output port.
- Sits between the serial lane front-ends and the word-level consumer.

Parameters:
- NUM_CH, 4, number of serial requesters (≥2).
- SIZE, 8, bits per word; must match the attached SIPO SIZE.
- CW, $clog2(NUM_CH), width of the channel tag.

Ports:
- clk  in  1  clock.
- reset_n  in  1  synchronous active-low reset.
- req  in  NUM_CH  per-channel frame request; must stay high for the whole frame.
- ser_in  in  NUM_CH  per-channel serial data.
- gnt  out  NUM_CH  one-hot grant; high while the channel's bits are being shifted.
- sipo_en  out  1  to SIPO enable.
- sipo_in  out  1  to SIPO serial input.
- sipo_clr  out  1  to SIPO reset (active-high).
- sipo_out  in  SIZE  SIPO parallel word.
- sipo_done  in  1  SIPO done flag.
- word_out  out  SIZE  captured word.
- word_ch  out  CW  channel that produced word_out.
- word_valid  out  1  output word valid.
- word_ready  in  1  consumer accepts the word.
- busy  out  1  high in any state other than IDLE.
- abort  out  1  one-cycle pulse on an aborted frame.

Behaviour:
- Reset (reset_n low at a rising edge), from any state including mid-frame:
  - State becomes IDLE.
  - gnt, sipo_en, word_valid, busy, abort, word_out, word_ch, bit counter all 0.
  - sipo_clr = 1.
  - Round-robin pointer last = NUM_CH-1, so channel 0 has highest priority first.
- sipo_clr deasserts on the first edge after reset_n goes high; elsewhere it is high only as specified below.
- sipo_in = ser_in[granted channel] when sipo_en = 1, else 0. This is a combinational mux.
- sipo_en = |gnt.
- FSM states: IDLE, SHIFT, CAPTURE, HOLD.
- IDLE:
  - If any req bit is high, select the first requesting channel scanning last+1, last+2, … modulo NUM_CH.
  - Register its one-hot gnt, clear the bit counter, go to SHIFT.
  - With no requests, stay in IDLE.
- SHIFT:
  - gnt is held for exactly SIZE cycles; the counter runs 0..SIZE-1.
  - The granted requester drives bit k during the k-th gnt cycle.
  - If the counter = SIZE-1: drop gnt, go to CAPTURE.
  - If req[granted] is low on any SHIFT edge:
    - Drop gnt.
    - Pulse abort and sipo_clr for one cycle.
    - Set last = granted channel.
    - Go to IDLE; no word is produced.
- CAPTURE (one cycle; the SIPO registers done one edge after its last enabled bit):
  - If sipo_done = 1: word_out <= sipo_out, word_ch <= granted index, word_valid <= 1, go to HOLD.
  - If sipo_done = 0: pulse abort and sipo_clr, set last = granted, go to IDLE.
- HOLD:
  - word_valid, word_out and word_ch are held stable until word_valid && word_ready at an edge.
  - On that edge: word_valid <= 0, last = granted channel, go to IDLE.
  - word_ready while word_valid is low is ignored.
- Latency:
  - req sampled high at edge E0 → gnt high after E0 through edge E_SIZE.
  - word_valid high after edge E_SIZE+1.
  - After acceptance there is one IDLE cycle before the next grant. Throughput is one word per SIZE+3 cycles with ready tied high.
- Simultaneous requests: only the round-robin winner is granted; the others wait with no starvation.
- A new req arriving during SHIFT, CAPTURE or HOLD is not granted until IDLE.
- gnt is always one-hot or zero.

Test Plan:
- Reset: hold reset_n low 3 cycles mid-SHIFT → gnt = 0, word_valid = 0, sipo_clr = 1, busy = 0. The first grant after release goes to channel 0 when req = 4'b1111.
- Single frame, NUM_CH = 4, SIZE = 8: req[2] high, ch2 streams 1,0,1,1,0,0,1,0 → gnt = 4'b0100 for 8 cycles, then word_valid after 9 cycles with word_ch = 2 and word_out equal to the SIPO word (LSB-first 8'h4D). word_ready = 1 clears it in one cycle.
- Round robin: req = 4'b1011 held, word_ready = 1 → grant order 0, 1, 3, 0, 1, 3. Each word is tagged correctly, with SIZE+3-cycle spacing.
- Backpressure: word_ready = 0 for 20 cycles after word_valid → word_out and word_ch are stable, no new gnt, busy = 1. Raising word_ready gives acceptance, and the next grant follows after one IDLE cycle.
- Abort: drop req[1] at bit 4 → gnt drops next cycle, abort and sipo_clr pulse once, no word_valid. With req = 4'b0011, channel 0 is granted next.
- Missing done: force sipo_done = 0 in CAPTURE → abort pulse, sipo_clr pulse, return to IDLE, word_valid stays 0.
